instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Upstream feeder for the 4-state datapath control unit. Holds a small writable
//  instruction store and a program counter, presents instr[15:0] and drives run.
//  Advances PC on each retired instruction (control unit done). Supports stop,
//  single-step, loop/halt at end of program. Keeps the control unit aligned to S0.
// PARAMETERS
//  DEPTH  16  instruction store entries
//  AW     4   address width, log2(DEPTH)
//  IW     16  instruction width
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  start      in   1      pulse: begin execution at address 0
//  stop       in   1      pulse: stop at next instruction boundary
//  step_mode  in   1      1 = pause after every retired instruction
//  step       in   1      pulse: resume one instruction while paused
//  loop_en    in   1      1 = wrap to 0 after last instr, 0 = halt
//  prog_len   in   AW+1   program length; values >DEPTH clamp to DEPTH
//  prog_we    in   1      store write enable
//  prog_addr  in   AW     store write address
//  prog_data  in   IW     store write data
//  done       in   1      from control unit: high in final state (S3)
//  instr      out  IW     store[pc], combinational read, to control unit
//  run        out  1      advance enable to control unit
//  pc         out  AW     current program counter
//  busy       out  1      state is RUN or PAUSE
//  halted     out  1      state is HALT
//  icount     out  16     retired-instruction count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, icount=0, store cleared to 0, run=0, busy=0,
//   halted=0, instr=0, stop_pend=0. Control unit shares rst, so both restart at S0.
//  Retire event R = (state==RUN) & done, sampled on clk rising edge.
//  States: IDLE, RUN, PAUSE, HALT. run=1 only in RUN (Moore output).
//  IDLE/HALT: start & eff_len!=0 -> RUN, pc<=0, stop_pend<=0; start ignored if
//   eff_len==0. prog_we writes store[prog_addr]<=prog_data on clk edge.
//  RUN: stop sets stop_pend. On R: icount++ (saturating); then in priority order:
//   stop_pend|stop -> IDLE, pc<=pc+1 (or 0 if last);
//   pc==eff_len-1 & !loop_en -> HALT, pc held;
//   pc==eff_len-1 & loop_en -> pc<=0, then step_mode ? PAUSE : RUN;
//   else pc<=pc+1, then step_mode ? PAUSE : RUN.
//  PAUSE: run=0 (control unit holds in S0). step -> RUN; stop -> IDLE;
//   stop+step in the same cycle -> IDLE.
//  Each instruction occupies exactly 4 RUN cycles; instr stable the whole time,
//   changes only at the edge where R=1.
//  prog_we outside IDLE/HALT ignored (store protected while busy).
//  start in RUN/PAUSE ignored; step outside PAUSE ignored.
//  stop never aborts mid-instruction; run stays 1 until done.
//  rst mid-instruction: immediate return to reset values, store cleared.
//  eff_len = min(prog_len, DEPTH); prog_len sampled live, not latched.
// TESTING
//  1. Load A,B,C at addr 0-2, prog_len=3, loop_en=0, start -> run=1 for 12 cycles,
//     instr A,B,C for 4 cycles each, pc 0,1,2, then halted=1, run=0, icount=3.
//  2. prog_len=2, loop_en=1, start -> pc 0,1,0,1,... ; icount=5 after 20 cycles.
//  3. loop run; stop on 2nd cycle of instr at pc=0 -> run stays 1 until done;
//     IDLE with pc=1 at retire; icount=1; control unit back in S0.
//  4. step_mode=1, start -> run=0 after 4 cycles, pc=1; no step for 10 cycles ->
//     run stays 0; step pulse -> 4 more RUN cycles, pc=2.
//  5. prog_we to addr 0 while busy -> store unchanged. prog_len=0 + start -> stays
//     IDLE. prog_len=20 -> wraps at pc=15.
//  6. Assert rst on 3rd cycle of an instruction -> pc=0, icount=0, run=0, instr=0.

Source files
------------

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : instr_sequencer
// Purpose : Instruction store + program counter feeding a 4-state control unit.
// Rev     : 1.0  initial release
// ============================================================================
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          step_mode,
  input  logic          step,
  input  logic          loop_en,
  input  logic [AW:0]   prog_len,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          done,
  output logic [IW-1:0] instr,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [15:0]   icount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  state_t        state;
  logic          stop_pend;
  logic [IW-1:0] mem [DEPTH];

  logic [AW:0]   eff_len;
  logic          is_last;
  logic          retire;
  logic [AW-1:0] pc_next;
  logic          store_open;

  // Program length is used live so the host may shorten a looping program.
  assign eff_len    = (prog_len > C_DEPTH) ? C_DEPTH : prog_len;
  assign is_last    = ({1'b0, pc} == (eff_len - 1'b1));
  assign retire     = (state == RUN) && done;
  assign pc_next    = is_last ? '0 : pc + 1'b1;
  assign store_open = (state == IDLE) || (state == HALT);

  assign instr  = mem[pc];
  assign run    = (state == RUN);
  assign busy   = (state == RUN) || (state == PAUSE);
  assign halted = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (prog_we && store_open) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      icount    <= '0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start && (eff_len != '0)) begin
            state     <= RUN;
            pc        <= '0;
            stop_pend <= 1'b0;
          end
        end
        RUN: begin
          if (stop) stop_pend <= 1'b1;
          // A stop request only takes effect at the instruction boundary.
          if (retire) begin
            stop_pend <= 1'b0;
            if (icount != 16'hFFFF) icount <= icount + 16'd1;
            if (stop_pend || stop) begin
              state <= IDLE;
              pc    <= pc_next;
            end else if (is_last && !loop_en) begin
              state <= HALT;
            end else begin
              pc    <= pc_next;
              state <= step_mode ? PAUSE : RUN;
            end
          end
        end
        PAUSE: begin
          if (stop)      state <= IDLE;
          else if (step) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_instr_sequencer
// Purpose : Self-checking bench with a 4-state control unit model and scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, step_mode, step, loop_en;
  logic [AW:0]   prog_len;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          done;
  logic [IW-1:0] instr;
  logic          run, busy, halted;
  logic [AW-1:0] pc;
  logic [15:0]   icount;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
    .step(step), .loop_en(loop_en), .prog_len(prog_len), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .done(done), .instr(instr),
    .run(run), .pc(pc), .busy(busy), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  // Control unit model: S0..S3, advances while run, done in S3.
  logic [1:0] cu;
  assign done = (cu == 2'd3);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cu <= 2'd0;
    else if (run) cu <= cu + 2'd1;
  end

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] prog [DEPTH];
  logic [IW-1:0] sb [$];
  logic [IW-1:0] sb_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every retire must match the next expected instruction.
  always @(negedge clk) begin
    if (!rst && run && done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_retire", 32'd1, 32'd0);
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_retire_instr", 32'(instr), 32'(sb_exp));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 0; stop = 0; step = 0; step_mode = 0; loop_en = 0;
    prog_len = '0; prog_we = 0; prog_addr = '0; prog_data = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = prog[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_expected(input int len, input bit lp, input int nret);
    int eff;
    int p;
    eff = (len > DEPTH) ? DEPTH : len;
    p = 0;
    for (int r = 0; r < nret; r++) begin
      sb.push_back(prog[p]);
      p = (p == eff - 1) ? 0 : p + 1;
    end
    if (lp == 1'b0 && nret > eff) chk("tb_table_sanity", 32'(nret), 32'(eff));
  endtask

  typedef struct {
    int len; bit lp; bit sm; int ncyc;
    int exp_pc; int exp_ic; bit exp_run; bit exp_busy; bit exp_halt;
  } vec_t;
  vec_t vecs [8];

  initial begin
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'(16'h1357 * (i + 1));
    vecs[0] = '{3,  0, 0, 14, 2,  3,  0, 0, 1};
    vecs[1] = '{2,  1, 0, 20, 1,  5,  1, 1, 0};
    vecs[2] = '{0,  0, 0, 5,  0,  0,  0, 0, 0};
    vecs[3] = '{20, 0, 0, 66, 15, 16, 0, 0, 1};
    vecs[4] = '{20, 1, 0, 68, 1,  17, 1, 1, 0};
    vecs[5] = '{1,  0, 0, 4,  0,  1,  0, 0, 1};
    vecs[6] = '{3,  0, 1, 14, 1,  1,  0, 1, 0};
    vecs[7] = '{16, 1, 0, 40, 10, 10, 1, 1, 0};

    do_reset();
    chk("reset_pc",     32'(pc),     32'd0);
    chk("reset_icount", 32'(icount), 32'd0);
    chk("reset_run",    32'(run),    32'd0);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_instr",  32'(instr),  32'd0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      load_prog();
      prog_len = (AW+1)'(vecs[v].len); loop_en = vecs[v].lp; step_mode = vecs[v].sm;
      push_expected(vecs[v].len, vecs[v].lp, vecs[v].exp_ic);
      kick();
      cycles(vecs[v].ncyc);
      chk("vec_pc",     32'(pc),     32'(vecs[v].exp_pc));
      chk("vec_icount", 32'(icount), 32'(vecs[v].exp_ic));
      chk("vec_run",    32'(run),    32'(vecs[v].exp_run));
      chk("vec_busy",   32'(busy),   32'(vecs[v].exp_busy));
      chk("vec_halted", 32'(halted), 32'(vecs[v].exp_halt));
      chk("vec_sb_drained", 32'(sb.size()), 32'd0);
    end

    // Three-instruction program: instr and pc stable for 4 cycles each.
    do_reset(); load_prog();
    prog_len = 5'd3; loop_en = 0; step_mode = 0;
    push_expected(3, 0, 3);
    kick();
    for (int c = 0; c < 12; c++) begin
      chk("seq_run",   32'(run),   32'd1);
      chk("seq_pc",    32'(pc),    32'(c / 4));
      chk("seq_instr", 32'(instr), 32'(prog[c / 4]));
      @(negedge clk);
    end
    chk("seq_halted", 32'(halted), 32'd1);
    chk("seq_run_end", 32'(run),   32'd0);
    chk("seq_icount", 32'(icount), 32'd3);

    // Stop during an instruction waits for done.
    do_reset(); load_prog();
    prog_len = 5'd2; loop_en = 1;
    push_expected(2, 1, 1);
    kick();
    cycles(1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("stop_run_c3", 32'(run), 32'd1);
    @(negedge clk);
    chk("stop_run_c4", 32'(run), 32'd1);
    @(negedge clk);
    chk("stop_busy",   32'(busy),   32'd0);
    chk("stop_halted", 32'(halted), 32'd0);
    chk("stop_pc",     32'(pc),     32'd1);
    chk("stop_icount", 32'(icount), 32'd1);
    chk("stop_cu_s0",  32'(cu),     32'd0);

    // Single-step mode.
    do_reset(); load_prog();
    prog_len = 5'd3; loop_en = 0; step_mode = 1;
    push_expected(3, 0, 2);
    kick();
    cycles(4);
    chk("step_paused_run", 32'(run),  32'd0);
    chk("step_paused_pc",  32'(pc),   32'd1);
    chk("step_paused_busy", 32'(busy), 32'd1);
    cycles(10);
    chk("step_hold_run", 32'(run), 32'd0);
    chk("step_hold_pc",  32'(pc),  32'd1);
    step = 1'b1; @(negedge clk); step = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("step_run_cycle", 32'(run), 32'd1);
      @(negedge clk);
    end
    chk("step2_run",    32'(run),    32'd0);
    chk("step2_pc",     32'(pc),     32'd2);
    chk("step2_icount", 32'(icount), 32'd2);
    stop = 1'b1; step = 1'b1; @(negedge clk); stop = 1'b0; step = 1'b0;
    chk("stopstep_busy", 32'(busy), 32'd0);
    chk("stopstep_run",  32'(run),  32'd0);
    chk("stopstep_pc",   32'(pc),   32'd2);

    // Store write while busy is ignored; allowed again when idle.
    do_reset(); load_prog();
    prog_len = 5'd2; loop_en = 1; step_mode = 0;
    push_expected(2, 1, 2);
    kick();
    cycles(1);
    prog_we = 1'b1; prog_addr = '0; prog_data = 16'hDEAD;
    @(negedge clk);
    prog_we = 1'b0;
    cycles(2);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    cycles(3);
    chk("protect_busy",  32'(busy),  32'd0);
    chk("protect_pc",    32'(pc),    32'd0);
    chk("protect_instr", 32'(instr), 32'(prog[0]));
    prog_we = 1'b1; prog_addr = '0; prog_data = 16'hBEEF;
    @(negedge clk);
    prog_we = 1'b0;
    chk("idle_write_instr", 32'(instr), 32'h0000BEEF);
    prog_len = 5'd0;
    kick();
    cycles(3);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_run",  32'(run),  32'd0);

    // Asynchronous reset mid-instruction.
    do_reset(); load_prog();
    prog_len = 5'd3; loop_en = 0;
    push_expected(3, 0, 1);
    kick();
    cycles(6);
    chk("prerst_pc", 32'(pc), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_pc",     32'(pc),     32'd0);
    chk("rst_icount", 32'(icount), 32'd0);
    chk("rst_run",    32'(run),    32'd0);
    chk("rst_instr",  32'(instr),  32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_sb_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
